// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order retirement buffer for the Tomasulo core.
// Entries are allocated at dispatch (the id granted is the tail pointer and is
// also driven onto the rename port), completed out of order by writebacks, and
// retired one per cycle from the head in program order. A retiring branch whose
// actual outcome differs from its prediction still commits its own result, then
// raises pred_fail_flag for one cycle with redirect_pc and flushes the buffer.
//
// Parameters
//   ROB_SIZE_LOG   log2 of the number of entries (SIZE = 2**ROB_SIZE_LOG)
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active low
//   rdy            global enable; 0 freezes every register
//   alloc_*        dispatch request (valid, destination reg, branch flag, prediction)
//   alloc_ready    an entry can be granted this cycle
//   alloc_robid    id that would be granted (tail)
//   rename_*       rename port towards the register file (valid, reg, rob id)
//   wb_*           execution writeback (valid, rob id, value, taken, target)
//   qj, qk         operand lookup ids from dispatch
//   j_/k_ready     operand entry busy and its value available (incl. same-cycle wb)
//   j_/k_value     operand value, forwarded from wb_value on a same-cycle hit
//   commit_*       registered retirement port, one pulse per retired entry
//   pred_fail_flag registered one-cycle mispredict pulse
//   redirect_pc    registered correct pc, meaningful while pred_fail_flag is 1
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int ROB_SIZE_LOG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,

  input  logic                    alloc_valid,
  input  logic [4:0]              alloc_regid,
  input  logic                    alloc_is_br,
  input  logic                    alloc_pred,
  output logic                    alloc_ready,
  output logic [ROB_SIZE_LOG-1:0] alloc_robid,

  output logic                    rename_valid,
  output logic [4:0]              rename_regid,
  output logic [ROB_SIZE_LOG-1:0] rename_robid,

  input  logic                    wb_valid,
  input  logic [ROB_SIZE_LOG-1:0] wb_robid,
  input  logic [31:0]             wb_value,
  input  logic                    wb_taken,
  input  logic [31:0]             wb_target,

  input  logic [ROB_SIZE_LOG-1:0] qj,
  input  logic [ROB_SIZE_LOG-1:0] qk,
  output logic                    j_ready,
  output logic                    k_ready,
  output logic [31:0]             j_value,
  output logic [31:0]             k_value,

  output logic                    commit_valid,
  output logic [4:0]              commit_regid,
  output logic [31:0]             commit_value,
  output logic [ROB_SIZE_LOG-1:0] commit_robid,

  output logic                    pred_fail_flag,
  output logic [31:0]             redirect_pc
);

  localparam int SIZE = 1 << ROB_SIZE_LOG;
  localparam logic [ROB_SIZE_LOG:0] FULL_COUNT = (ROB_SIZE_LOG+1)'(SIZE);

  // Control state
  logic [ROB_SIZE_LOG-1:0] head;
  logic [ROB_SIZE_LOG-1:0] tail;
  logic [ROB_SIZE_LOG:0]   count;
  logic [SIZE-1:0]         busy;
  logic [SIZE-1:0]         done;

  // Entry payload; only meaningful while the entry is busy, so no reset needed
  logic [SIZE-1:0]         is_br;
  logic [SIZE-1:0]         pred;
  logic [SIZE-1:0]         taken;
  logic [4:0]              regid_mem  [SIZE];
  logic [31:0]             value_mem  [SIZE];
  logic [31:0]             target_mem [SIZE];

  logic do_alloc;
  logic do_wb;
  logic do_commit;
  logic mispredict;
  logic j_hit;
  logic k_hit;

  // Full is judged on the registered count, so a commit in the same cycle
  // never frees a slot early.
  assign alloc_ready  = (count < FULL_COUNT) && !pred_fail_flag;
  assign alloc_robid  = tail;
  assign rename_valid = alloc_valid && alloc_ready;
  assign rename_regid = alloc_regid;
  assign rename_robid = tail;

  assign do_alloc   = rename_valid;
  // Writebacks in the cycle after a flush belong to squashed instructions.
  assign do_wb      = wb_valid && busy[wb_robid] && !pred_fail_flag;
  assign do_commit  = busy[head] && done[head] && !pred_fail_flag;
  assign mispredict = do_commit && is_br[head] && (taken[head] != pred[head]);

  // Operand lookup with same-cycle writeback forwarding
  assign j_hit   = wb_valid && (wb_robid == qj);
  assign k_hit   = wb_valid && (wb_robid == qk);
  assign j_ready = busy[qj] && (done[qj] || j_hit);
  assign k_ready = busy[qk] && (done[qk] || k_hit);
  assign j_value = (j_hit && !done[qj]) ? wb_value : value_mem[qj];
  assign k_value = (k_hit && !done[qk]) ? wb_value : value_mem[qk];

  // Pointers, occupancy, status bits and the registered output ports
  always_ff @(posedge clk) begin
    if (!rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      busy           <= '0;
      done           <= '0;
      commit_valid   <= 1'b0;
      commit_regid   <= '0;
      commit_value   <= '0;
      commit_robid   <= '0;
      pred_fail_flag <= 1'b0;
      redirect_pc    <= '0;
    end else if (rdy) begin
      commit_valid   <= do_commit;
      pred_fail_flag <= mispredict;

      if (do_commit) begin
        commit_regid <= regid_mem[head];
        commit_value <= value_mem[head];
        commit_robid <= head;
      end

      if (mispredict) begin
        // The branch retires, everything younger is squashed on this edge.
        redirect_pc <= target_mem[head];
        busy        <= '0;
        done        <= '0;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
      end else begin
        if (do_wb) begin
          done[wb_robid] <= 1'b1;
        end
        if (do_commit) begin
          busy[head] <= 1'b0;
          done[head] <= 1'b0;
          head       <= head + 1'b1;
        end
        // Placed last so an alloc wins over a writeback to the same id.
        if (do_alloc) begin
          busy[tail] <= 1'b1;
          done[tail] <= 1'b0;
          tail       <= tail + 1'b1;
        end
        case ({do_alloc, do_commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage
  always_ff @(posedge clk) begin
    if (rst && rdy) begin
      if (do_wb) begin
        value_mem[wb_robid]  <= wb_value;
        taken[wb_robid]      <= wb_taken;
        target_mem[wb_robid] <= wb_target;
      end
      if (do_alloc) begin
        regid_mem[tail] <= alloc_regid;
        is_br[tail]     <= alloc_is_br;
        pred[tail]      <= alloc_pred;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  localparam int LOG  = 4;
  localparam int SIZE = 16;

  logic            clk;
  logic            rst;
  logic            rdy;
  logic            alloc_valid;
  logic [4:0]      alloc_regid;
  logic            alloc_is_br;
  logic            alloc_pred;
  logic            alloc_ready;
  logic [LOG-1:0]  alloc_robid;
  logic            rename_valid;
  logic [4:0]      rename_regid;
  logic [LOG-1:0]  rename_robid;
  logic            wb_valid;
  logic [LOG-1:0]  wb_robid;
  logic [31:0]     wb_value;
  logic            wb_taken;
  logic [31:0]     wb_target;
  logic [LOG-1:0]  qj;
  logic [LOG-1:0]  qk;
  logic            j_ready;
  logic            k_ready;
  logic [31:0]     j_value;
  logic [31:0]     k_value;
  logic            commit_valid;
  logic [4:0]      commit_regid;
  logic [31:0]     commit_value;
  logic [LOG-1:0]  commit_robid;
  logic            pred_fail_flag;
  logic [31:0]     redirect_pc;

  reorder_buffer #(.ROB_SIZE_LOG(LOG)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_regid(alloc_regid),
    .alloc_is_br(alloc_is_br), .alloc_pred(alloc_pred),
    .alloc_ready(alloc_ready), .alloc_robid(alloc_robid),
    .rename_valid(rename_valid), .rename_regid(rename_regid), .rename_robid(rename_robid),
    .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_value(wb_value),
    .wb_taken(wb_taken), .wb_target(wb_target),
    .qj(qj), .qk(qk), .j_ready(j_ready), .k_ready(k_ready),
    .j_value(j_value), .k_value(k_value),
    .commit_valid(commit_valid), .commit_regid(commit_regid),
    .commit_value(commit_value), .commit_robid(commit_robid),
    .pred_fail_flag(pred_fail_flag), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass    = 0;
  int n_total   = 0;
  int n_commits = 0;

  // Reference model: program-order queue of outstanding ids plus per-id payload
  int          exp_q[$];
  int          m_tail = 0;
  logic [4:0]  m_reg   [SIZE];
  logic [31:0] m_val   [SIZE];
  logic [31:0] m_tgt   [SIZE];
  logic        m_br    [SIZE];
  logic        m_pred  [SIZE];
  logic        m_taken [SIZE];

  int   mon_id;
  logic mon_mp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst         = 1'b0;
    alloc_valid = 1'b0;
    wb_valid    = 1'b0;
    cyc();
    cyc();
    exp_q.delete();
    m_tail = 0;
    rst    = 1'b1;
  endtask

  task automatic do_alloc(input logic [4:0] r, input logic br, input logic p);
    int w = 0;
    while (!alloc_ready && w < 100) begin
      cyc();
      w++;
    end
    chk("alloc_ready_wait", alloc_ready, 1);
    alloc_valid = 1'b1;
    alloc_regid = r;
    alloc_is_br = br;
    alloc_pred  = p;
    #1;
    chk("alloc_robid", alloc_robid, m_tail);
    chk("rename_valid", rename_valid, 1);
    chk("rename_regid", rename_regid, r);
    m_reg[m_tail]  = r;
    m_br[m_tail]   = br;
    m_pred[m_tail] = p;
    exp_q.push_back(m_tail);
    m_tail = (m_tail + 1) % SIZE;
    cyc();
    alloc_valid = 1'b0;
  endtask

  task automatic wb_set(input int id, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    wb_valid  = 1'b1;
    wb_robid  = id[LOG-1:0];
    wb_value  = v;
    wb_taken  = tk;
    wb_target = tg;
    m_val[id]   = v;
    m_taken[id] = tk;
    m_tgt[id]   = tg;
  endtask

  task automatic do_wb(input int id, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    wb_set(id, v, tk, tg);
    cyc();
    wb_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      cyc();
      w++;
    end
    chk("drain", exp_q.size(), 0);
    cyc();
    cyc();
  endtask

  // A commit is consumed on a rising edge with rdy high; check it against the
  // oldest outstanding id in the model.
  always @(negedge clk) begin
    if (rst === 1'b1 && rdy === 1'b1 && commit_valid === 1'b1) begin
      n_commits++;
      if (exp_q.size() == 0) begin
        chk("spurious_commit", commit_valid, 0);
      end else begin
        mon_id = exp_q.pop_front();
        mon_mp = m_br[mon_id] && (m_taken[mon_id] != m_pred[mon_id]);
        chk("commit_robid", commit_robid, mon_id);
        chk("commit_regid", commit_regid, m_reg[mon_id]);
        chk("commit_value", commit_value, m_val[mon_id]);
        chk("pred_fail_flag", pred_fail_flag, mon_mp);
        if (mon_mp) begin
          chk("redirect_pc", redirect_pc, m_tgt[mon_id]);
          chk("alloc_blocked_on_flush", alloc_ready, 0);
          exp_q.delete();
          m_tail = 0;
        end
      end
    end
  end

  initial begin
    int base;
    int total;
    int b;
    int ids[6];
    int tmp;
    int jx;
    int w;

    rdy = 1'b1; alloc_regid = '0; alloc_is_br = 1'b0; alloc_pred = 1'b0;
    wb_robid = '0; wb_value = '0; wb_taken = 1'b0; wb_target = '0;
    qj = '0; qk = '0;

    // 1: reset state
    apply_reset();
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_pred_fail", pred_fail_flag, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_robid", alloc_robid, 0);

    // 2: out-of-order writeback, in-order commit, operand lookup
    base = n_commits;
    do_alloc(5'd1, 1'b0, 1'b0);
    do_alloc(5'd2, 1'b0, 1'b0);
    do_alloc(5'd3, 1'b0, 1'b0);
    qj = 4'd0; qk = 4'd3; #1;
    chk("j_ready_not_done", j_ready, 0);
    chk("k_ready_not_busy", k_ready, 0);
    do_wb(2, 32'h33, 1'b0, 32'h0);
    wb_set(0, 32'h11, 1'b0, 32'h0);
    qj = 4'd2; qk = 4'd0; #1;
    chk("j_ready_done", j_ready, 1);
    chk("j_value_done", j_value, 32'h33);
    chk("k_ready_fwd", k_ready, 1);
    chk("k_value_fwd", k_value, 32'h11);
    cyc();
    wb_valid = 1'b0;
    do_wb(1, 32'h22, 1'b0, 32'h0);
    wait_drain();
    chk("t2_commit_count", n_commits - base, 3);
    // writeback to an idle entry is dropped
    base = n_commits;
    do_wb(7, 32'hDEAD, 1'b0, 32'h0);
    qj = 4'd7; #1;
    chk("wb_idle_ignored", j_ready, 0);
    cyc(); cyc(); cyc();
    chk("wb_idle_no_commit", n_commits - base, 0);

    // 3: full buffer
    apply_reset();
    for (int i = 0; i < SIZE; i++) do_alloc(5'(i + 1), 1'b0, 1'b0);
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_alloc_robid", alloc_robid, 0);
    alloc_valid = 1'b1; alloc_regid = 5'd31; #1;
    chk("full_rename_blocked", rename_valid, 0);
    cyc();
    alloc_valid = 1'b0;
    chk("full_tail_held", alloc_robid, 0);
    do_wb(0, 32'hC0, 1'b0, 32'h0);
    w = 0;
    while (exp_q.size() == SIZE && w < 20) begin cyc(); w++; end
    chk("full_one_commit", exp_q.size(), SIZE - 1);
    chk("after_commit_ready", alloc_ready, 1);
    chk("after_commit_robid", alloc_robid, 0);
    // reset in the middle of a full buffer
    apply_reset();
    chk("midrst_commit_valid", commit_valid, 0);
    chk("midrst_alloc_ready", alloc_ready, 1);
    chk("midrst_alloc_robid", alloc_robid, 0);

    // 4: mispredict at commit flushes younger done entries
    apply_reset();
    base = n_commits;
    do_alloc(5'd5, 1'b0, 1'b0);
    do_alloc(5'd6, 1'b1, 1'b0);
    do_alloc(5'd7, 1'b0, 1'b0);
    do_alloc(5'd8, 1'b0, 1'b0);
    do_alloc(5'd9, 1'b0, 1'b0);
    do_wb(2, 32'h200, 1'b0, 32'h0);
    do_wb(3, 32'h300, 1'b0, 32'h0);
    do_wb(4, 32'h400, 1'b0, 32'h0);
    do_wb(1, 32'h111, 1'b1, 32'h100);
    do_wb(0, 32'h0AB, 1'b0, 32'h0);
    wait_drain();
    cyc(); cyc(); cyc();
    chk("flush_commit_count", n_commits - base, 2);
    chk("flush_pred_fail_cleared", pred_fail_flag, 0);
    chk("flush_alloc_ready", alloc_ready, 1);
    chk("flush_alloc_robid", alloc_robid, 0);

    // 5: randomized batches, 20 entries, pointer wrap
    apply_reset();
    base  = n_commits;
    total = 0;
    while (total < 20) begin
      b = $urandom_range(1, 6);
      if (b > 20 - total) b = 20 - total;
      for (int i = 0; i < b; i++) begin
        ids[i] = m_tail;
        do_alloc(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      for (int k = b - 1; k > 0; k--) begin
        jx = $urandom_range(0, k);
        tmp = ids[k]; ids[k] = ids[jx]; ids[jx] = tmp;
      end
      for (int i = 0; i < b; i++) begin
        do_wb(ids[i], $urandom, m_pred[ids[i]], $urandom);
        if ($urandom_range(0, 3) == 0) cyc();
      end
      wait_drain();
      total += b;
    end
    chk("rand_commit_count", n_commits - base, 20);
    chk("rand_final_robid", alloc_robid, 4);

    // 6: rdy freeze holds a pending commit; wb->commit latency
    apply_reset();
    do_alloc(5'd4, 1'b0, 1'b0);
    do_wb(0, 32'hAA, 1'b0, 32'h0);
    chk("latency_n1", commit_valid, 0);
    cyc();
    chk("latency_n2", commit_valid, 1);
    base = n_commits;
    rdy = 1'b0;
    alloc_valid = 1'b1; alloc_regid = 5'd9;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_commit_valid", commit_valid, 1);
      chk("hold_commit_value", commit_value, 32'hAA);
      chk("hold_commit_robid", commit_robid, 0);
      chk("hold_tail", alloc_robid, 1);
    end
    alloc_valid = 1'b0;
    rdy = 1'b1;
    cyc();
    cyc();
    chk("resume_commit_valid", commit_valid, 0);
    chk("resume_one_commit", n_commits - base, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
